// File: rtl/prog_clock_divider.sv
// Multi-channel programmable integer clock divider with a single-slot divisor update port.
// Optional feature: define CLKDIV_SYNC_EN to add the sync_start phase-alignment input.
module prog_clock_divider #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 2,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_start,
`endif
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] div_tick
);

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);
  localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(2);

  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  div     [NUM_CH];
  logic [CNT_W-1:0]  last    [NUM_CH];
  logic [CNT_W-1:0]  half_m1 [NUM_CH];
  logic [NUM_CH-1:0] wrap;

  logic              pend_valid;
  logic              rel;
  logic [CH_W-1:0]   pend_ch;
  logic [CNT_W-1:0]  pend_div;
  logic [CNT_W-1:0]  cfg_div_c;
  logic              cfg_ch_ok;
  logic              sync;

`ifdef CLKDIV_SYNC_EN
  assign sync = sync_start;
`else
  assign sync = 1'b0;
`endif

  assign cfg_div_c = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
  assign cfg_ch_ok = int'(cfg_ch) < NUM_CH;
  // rel covers the single cycle between a load/drop and the slot reopening
  assign cfg_ready = ~(pend_valid | rel);

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      last[c]    = div[c] - CNT_W'(1);
      half_m1[c] = (div[c] >> 1) + CNT_W'(div[c][0]) - CNT_W'(1);
      wrap[c]    = ch_en[c] && (cnt[c] == last[c]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      div_clk  <= '0;
      div_tick <= '0;
    end else if (sync) begin
      for (int unsigned c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      div_clk  <= '0;
      div_tick <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!ch_en[c]) begin
          cnt[c]      <= '0;
          div_clk[c]  <= 1'b0;
          div_tick[c] <= 1'b0;
        end else begin
          cnt[c]      <= wrap[c] ? '0 : cnt[c] + CNT_W'(1);
          div_tick[c] <= wrap[c];
          if (wrap[c])
            div_clk[c] <= 1'b1;
          else if (cnt[c] == half_m1[c])
            div_clk[c] <= 1'b0;
        end
      end
    end
  end

  // A capture takes priority only when the slot is empty, so a capture that lands on the
  // target's wrap edge is checked from the following edge and waits for the next wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) div[c] <= DIV_INIT;
      pend_valid <= 1'b0;
      rel        <= 1'b0;
      pend_ch    <= '0;
      pend_div   <= '0;
    end else if (cfg_valid && cfg_ready) begin
      if (cfg_ch_ok) begin
        pend_valid <= 1'b1;
        pend_ch    <= cfg_ch;
        pend_div   <= cfg_div_c;
      end else begin
        rel <= 1'b1;
      end
    end else if (pend_valid && (sync || wrap[pend_ch] || !ch_en[pend_ch])) begin
      div[pend_ch] <= pend_div;
      pend_valid   <= 1'b0;
      rel          <= 1'b1;
    end else if (rel) begin
      rel <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed self-checking bench for prog_clock_divider (3 channels so an out-of-range cfg_ch is expressible).
module tb_prog_clock_divider;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] div_clk;
  logic [NUM_CH-1:0] div_tick;
`ifdef CLKDIV_SYNC_EN
  logic              sync_start = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  prog_clock_divider #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_RST(2)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CLKDIV_SYNC_EN
    .sync_start(sync_start),
`endif
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .div_clk   (div_clk),
    .div_tick  (div_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected output k enabled edges after a fresh start with divisor d.
  function automatic logic eclk(input int k, input int d);
    return (k >= d) && (((k - d) % d) < ((d + 1) / 2));
  endfunction

  function automatic logic etick(input int k, input int d);
    return (k >= d) && (((k - d) % d) == 0);
  endfunction

  task automatic cfg_write(input logic [1:0] ch, input logic [CNT_W-1:0] dv);
    int n;
    check("cfg_rdy_pre", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = dv;
    step(1);
    cfg_valid = 1'b0;
    n = 0;
    while (!cfg_ready && n < 20) begin
      step(1);
      n++;
    end
    check("cfg_done", cfg_ready, 1);
  endtask

  initial begin
    rst       = 1'b0;
    ch_en     = '1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    #12;
    check("rst_clk",   div_clk,   0);
    check("rst_tick",  div_tick,  0);
    check("rst_ready", cfg_ready, 1);
    rst = 1'b1;

    // 1: reset divisor 2 on every channel
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check("t1_clk",  div_clk,  (k % 2 == 0) ? 3'b111 : 3'b000);
      check("t1_tick", div_tick, (k % 2 == 0) ? 3'b111 : 3'b000);
    end

    // 2: ch1 -> 5, others stay at 2
    ch_en = '0;
    step(1);
    cfg_write(2'd1, 8'd5);
    ch_en = '1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check("t2_clk",  div_clk,  {eclk(k, 2),  eclk(k, 5),  eclk(k, 2)});
      check("t2_tick", div_tick, {etick(k, 2), etick(k, 5), etick(k, 2)});
    end

    // 3: ch2 at 4, write 6 mid-period; load waits for the wrap at edge 4
    ch_en = 3'b011;
    step(1);
    cfg_write(2'd2, 8'd4);
    ch_en = 3'b111;
    for (int k = 1; k <= 11; k++) begin
      int m;
      step(1);
      m = k - 4;
      if (k < 4) begin
        check("t3_clk",  div_clk[2],  eclk(k, 4));
        check("t3_tick", div_tick[2], etick(k, 4));
      end else begin
        check("t3_clk",  div_clk[2],  (m % 6) < 3);
        check("t3_tick", div_tick[2], (m % 6) == 0);
      end
      check("t3_ready", cfg_ready, (k == 3 || k == 4) ? 0 : 1);
      if (k == 2) begin
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_div   = 8'd6;
      end
      if (k == 3) cfg_valid = 1'b0;
    end

    // 4: clamp of 0/1 and out-of-range channel
    ch_en = '0;
    step(1);
    cfg_write(2'd1, 8'd0);
    cfg_write(2'd2, 8'd1);
    cfg_valid = 1'b1;
    cfg_ch    = 2'd3;
    cfg_div   = 8'd9;
    step(1);
    cfg_valid = 1'b0;
    check("t4_bad_ready0", cfg_ready, 0);
    step(1);
    check("t4_bad_ready1", cfg_ready, 1);
    ch_en = '1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check("t4_clk",  div_clk,  {3{eclk(k, 2)}});
      check("t4_tick", div_tick, {3{etick(k, 2)}});
    end

    // 5: synchronous stop, restart, reset with an update pending
    ch_en = '0;
    step(1);
    cfg_write(2'd1, 8'd3);
    ch_en = '1;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      check("t5_clk", div_clk, {eclk(k, 2), eclk(k, 3), eclk(k, 2)});
    end
    ch_en = '0;
    step(1);
    check("t5_stop_clk",  div_clk,  0);
    check("t5_stop_tick", div_tick, 0);
    ch_en = '1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check("t5_re_clk",  div_clk,  {eclk(k, 2),  eclk(k, 3),  eclk(k, 2)});
      check("t5_re_tick", div_tick, {etick(k, 2), etick(k, 3), etick(k, 2)});
    end
    cfg_valid = 1'b1;
    cfg_ch    = 2'd1;
    cfg_div   = 8'd7;
    step(1);
    cfg_valid = 1'b0;
    check("t5_pend", cfg_ready, 0);
    rst = 1'b0;
    #1;
    check("t5_rst_ready", cfg_ready, 1);
    check("t5_rst_clk",   div_clk,   0);
    step(1);
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check("t5_post_clk", div_clk, {3{eclk(k, 2)}});
      check("t5_post_rdy", cfg_ready, 1);
    end

`ifdef CLKDIV_SYNC_EN
    // 6: two D=3 channels out of phase realigned by sync_start
    ch_en = '0;
    step(1);
    cfg_write(2'd0, 8'd3);
    cfg_write(2'd2, 8'd3);
    ch_en = 3'b001;
    step(1);
    ch_en = 3'b101;
    step(1);
    sync_start = 1'b1;
    step(1);
    sync_start = 1'b0;
    check("t6_sync_clk",  div_clk,  0);
    check("t6_sync_tick", div_tick, 0);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check("t6_clk",  {div_clk[2],  div_clk[0]},  {2{eclk(k, 3)}});
      check("t6_tick", {div_tick[2], div_tick[0]}, {2{etick(k, 3)}});
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
